// File: rtl/tile_pkg.sv
// Shared tile-array definitions: fmap element width and the skew feeder state encoding.
package tile_pkg;

  localparam int D_BW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// One fmap lane of the skew network: a DEPTH-stage, D_BW-wide shift register
// that advances only on shift_en and clears asynchronously.
module skew_lane
  import tile_pkg::*;
#(
  parameter int W     = D_BW,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stages;

  // NOTE: every stage is cleared on reset (not just the output) so a pass
  // aborted mid-flight cannot leak stale elements into the next pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking assignments make each stage take its neighbour's
      // old value, so the loop order does not matter.
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/fmap_skew_feeder.sv
// Feeds unskewed fmap beats into the tile array with lane k delayed by k shifts,
// then drains zeros until the last beat has fully emerged.
// Optional macro FEEDER_STALL_CNT_EN adds o_stall_cnt (RUN cycles without a beat).
module fmap_skew_feeder
#(
  parameter int D_BW   = tile_pkg::D_BW,
  parameter int LANES  = 25,
  parameter int LEN_BW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [LEN_BW-1:0]     i_len,
  input  logic                  i_valid,
  input  logic [D_BW*LANES-1:0] i_fmap,
  output logic                  o_ready,
  output logic [D_BW*LANES-1:0] o_fmap,
  output logic                  o_en_tf,
  output logic                  o_busy,
  output logic                  o_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [LEN_BW-1:0]     o_stall_cnt
`endif
);

  import tile_pkg::*;

  localparam logic [LEN_BW-1:0] CNT_ONE    = LEN_BW'(1);
  localparam logic [LEN_BW-1:0] DRAIN_LOAD = LEN_BW'(LANES - 1);

  feeder_state_t         state_q, state_d;
  logic [LEN_BW-1:0]     cnt_q, cnt_d;
  logic                  shift;
  logic                  en_q;
  logic [D_BW*LANES-1:0] lane_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= shift;
    end
  end

  // One counter serves both phases: beats left in RUN, zero-shifts left in DRAIN.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            state_d = ST_RUN;
            cnt_d   = i_len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (i_valid) begin
          shift = 1'b1;
          if (cnt_q == CNT_ONE) begin
            if (LANES == 1) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        shift  = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Upstream data only enters during RUN; DRAIN pushes zeros behind the last beat.
  assign lane_in = (state_q == ST_RUN) ? i_fmap : '0;
  assign o_en_tf = en_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_lane #(
      .W     (D_BW),
      .DEPTH (k + 1)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift),
      .d        (lane_in[k*D_BW +: D_BW]),
      .q        (o_fmap[k*D_BW +: D_BW])
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [LEN_BW-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == ST_IDLE && i_start && i_len != '0) begin
      stall_q <= '0;
    end else if (state_q == ST_RUN && !i_valid && stall_q != '1) begin
      stall_q <= stall_q + CNT_ONE;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fmap_skew_feeder.sv
// Self-checking bench for fmap_skew_feeder (LANES=4): directed scenarios plus
// randomized passes compared against a shift-history reference model.
module tb_fmap_skew_feeder;

  localparam int D_BW   = 8;
  localparam int LANES  = 4;
  localparam int LEN_BW = 16;
  localparam int FW     = D_BW * LANES;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [LEN_BW-1:0] i_len;
  logic              i_valid;
  logic [FW-1:0]     i_fmap;
  logic              o_ready;
  logic [FW-1:0]     o_fmap;
  logic              o_en_tf;
  logic              o_busy;
  logic              o_done;
`ifdef FEEDER_STALL_CNT_EN
  logic [LEN_BW-1:0] o_stall_cnt;
`endif

  fmap_skew_feeder #(
    .D_BW   (D_BW),
    .LANES  (LANES),
    .LEN_BW (LEN_BW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_len   (i_len),
    .i_valid (i_valid),
    .i_fmap  (i_fmap),
    .o_ready (o_ready),
    .o_fmap  (o_fmap),
    .o_en_tf (o_en_tf),
    .o_busy  (o_busy),
    .o_done  (o_done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: every shift event since reset is a lane-packed vector in
  // hist; lane k of the bus shows lane k of the entry k shifts back.
  logic [FW-1:0] hist[$];
  int  m_phase;   // 0 idle, 1 run, 2 drain, 3 done
  int  m_left;
  int  m_drain;
  int  m_stall;
  bit  m_en;

  logic [FW-1:0] obs_q[$];
  int  n_done_seen;
  int  n_en_seen;

  function automatic logic [FW-1:0] exp_fmap();
    logic [FW-1:0] r = '0;
    for (int k = 0; k < LANES; k++) begin
      int idx = hist.size() - 1 - k;
      if (idx >= 0) r[k*D_BW +: D_BW] = hist[idx][k*D_BW +: D_BW];
    end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_phase = 0;
    m_left  = 0;
    m_drain = 0;
    m_stall = 0;
    m_en    = 1'b0;
  endtask

  task automatic model_advance(input logic s, input int len, input logic v, input logic [FW-1:0] f);
    case (m_phase)
      0: begin
        m_en = 1'b0;
        if (s) begin
          if (len != 0) begin
            m_phase = 1;
            m_left  = len;
            m_stall = 0;
          end else begin
            m_phase = 3;
          end
        end
      end
      1: begin
        if (v) begin
          hist.push_back(f);
          m_en = 1'b1;
          m_left--;
          if (m_left == 0) begin
            m_phase = (LANES == 1) ? 3 : 2;
            m_drain = LANES - 1;
          end
        end else begin
          m_en = 1'b0;
          if (m_stall != 32'hffff) m_stall++;
        end
      end
      2: begin
        hist.push_back('0);
        m_en = 1'b1;
        m_drain--;
        if (m_drain == 0) m_phase = 3;
      end
      default: begin
        m_en    = 1'b0;
        m_phase = 0;
      end
    endcase
  endtask

  // Check outputs for the current cycle, then apply this cycle's inputs.
  task automatic cyc(input logic s, input int len, input logic v, input logic [FW-1:0] f);
    @(negedge clk);
    check("ready", o_ready, m_phase == 1);
    check("busy",  o_busy,  m_phase == 1 || m_phase == 2);
    check("done",  o_done,  m_phase == 3);
    check("en_tf", o_en_tf, m_en);
    check("fmap",  o_fmap,  exp_fmap());
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cnt", o_stall_cnt, m_stall);
`endif
    obs_q.push_back(o_fmap);
    n_done_seen += int'(o_done);
    n_en_seen   += int'(o_en_tf);
    i_start = s;
    i_len   = LEN_BW'(len);
    i_valid = v;
    i_fmap  = f;
    model_advance(s, len, v, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, FW'($urandom));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_fmap"},  o_fmap,  '0);
    check({tag, "_ready"}, o_ready, 1'b0);
    check({tag, "_en"},    o_en_tf, 1'b0);
    check({tag, "_busy"},  o_busy,  1'b0);
    check({tag, "_done"},  o_done,  1'b0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2;
    i_start = 1'b0;
    i_valid = 1'b0;
    rst     = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [FW-1:0] mk_beat(input logic [7:0] b);
    logic [FW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*D_BW +: D_BW] = b + 8'(k);
    return r;
  endfunction

  logic [FW-1:0] beat_a, beat_b, beat_c, final_ref;

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    i_len   = '0;
    i_valid = 1'b0;
    i_fmap  = '0;
    model_reset();
    #7;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    beat_a = mk_beat(8'h10);
    beat_b = mk_beat(8'h20);
    beat_c = mk_beat(8'h30);

    // Three beats back to back, valid held high.
    obs_q.delete();
    n_done_seen = 0;
    cyc(1'b1, 3, 1'b0, '0);
    cyc(1'b0, 0, 1'b1, beat_a);
    cyc(1'b0, 0, 1'b1, beat_b);
    cyc(1'b0, 0, 1'b1, beat_c);
    idle(8);
    check("l0_cyc1", obs_q[2][7:0], 8'h10);
    check("l0_cyc2", obs_q[3][7:0], 8'h20);
    check("l0_cyc3", obs_q[4][7:0], 8'h30);
    check("l3_cyc3", obs_q[4][31:24], 8'h00);
    check("l3_cyc4", obs_q[5][31:24], 8'h13);
    check("l3_cyc6", obs_q[7][31:24], 8'h33);
    check("done_at_cyc6", obs_q.size() > 7 ? 1'b1 : 1'b0, 1'b1);
    check("done_pulses", n_done_seen, 1);

    // Two beats without stall, then the same beats with a two-cycle stall.
    cyc(1'b1, 2, 1'b0, '0);
    cyc(1'b0, 0, 1'b1, beat_a);
    cyc(1'b0, 0, 1'b1, beat_b);
    idle(6);
    final_ref = obs_q[obs_q.size()-1];
    obs_q.delete();
    n_en_seen = 0;
    cyc(1'b1, 2, 1'b0, '0);
    cyc(1'b0, 0, 1'b1, beat_a);
    cyc(1'b0, 0, 1'b0, beat_c);
    cyc(1'b0, 0, 1'b0, beat_c);
    cyc(1'b0, 0, 1'b1, beat_b);
    idle(6);
    check("stall_frozen1", obs_q[3], obs_q[2]);
    check("stall_frozen2", obs_q[4], obs_q[2]);
    check("stall_final", obs_q[obs_q.size()-1], final_ref);
    check("stall_en_count", n_en_seen, 2 + LANES - 1);

    // Zero-length pass: DONE immediately, no array enable.
    n_en_seen   = 0;
    n_done_seen = 0;
    cyc(1'b1, 0, 1'b1, beat_a);
    idle(3);
    check("zero_len_en", n_en_seen, 0);
    check("zero_len_done", n_done_seen, 1);

    // Restart request during RUN is ignored.
    n_done_seen = 0;
    cyc(1'b1, 2, 1'b0, '0);
    cyc(1'b1, 7, 1'b1, beat_a);
    cyc(1'b1, 9, 1'b1, beat_b);
    idle(6);
    check("restart_ignored_done", n_done_seen, 1);

    // Reset during DRAIN, then a clean pass.
    n_done_seen = 0;
    cyc(1'b1, 2, 1'b0, '0);
    cyc(1'b0, 0, 1'b1, beat_a);
    cyc(1'b0, 0, 1'b1, beat_b);
    cyc(1'b0, 0, 1'b0, '0);
    pulse_rst();
    idle(4);
    check("rst_no_done", n_done_seen, 0);
    cyc(1'b1, 1, 1'b0, '0);
    cyc(1'b0, 0, 1'b1, beat_c);
    idle(6);

`ifdef FEEDER_STALL_CNT_EN
    cyc(1'b1, 2, 1'b0, '0);
    cyc(1'b0, 0, 1'b1, beat_a);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b0, beat_c);
    cyc(1'b0, 0, 1'b1, beat_b);
    idle(6);
    check("stall_cnt_5", o_stall_cnt, 5);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_rst();
      end else begin
        cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 6)),
            $urandom_range(0, 3) != 0, FW'($urandom));
      end
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmap_skew_feeder.md
FMAP_SKEW_FEEDER -- requirements
Module: fmap_skew_feeder

Interface
REQ-001 Parameter D_BW, default 8, bit width of one fmap element.
REQ-002 Parameter LANES, default 25 (COLS*T_COLS), number of element lanes driven into the tile array fmap bus.
REQ-003 Parameter LEN_BW, default 16, width of the beat-count input.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_start  input  1  single-cycle request to begin a pass; sampled only in IDLE.
REQ-007 i_len  input  LEN_BW  number of beats in the pass; sampled with i_start.
REQ-008 i_valid  input  1  upstream beat valid.
REQ-009 i_fmap  input  D_BW*LANES  unskewed beat; lane k at bits [(k+1)*D_BW-1 -: D_BW].
REQ-010 o_ready  output  1  feeder accepts a beat this cycle.
REQ-011 o_fmap  output  D_BW*LANES  skewed fmap bus to the tile array, same lane packing.
REQ-012 o_en_tf  output  1  array enable; high exactly on cycles following a shift event.
REQ-013 o_busy  output  1  high in RUN and DRAIN.
REQ-014 o_done  output  1  one-cycle pulse at pass completion.

Function
REQ-015 States IDLE, RUN, DRAIN, DONE; the state register is 2 bits.
REQ-016 IDLE: o_ready=0; i_start=1 with i_len>0 loads the beat counter and moves to RUN; i_start=1 with i_len=0 moves to DONE.
REQ-017 RUN: o_ready=1; a beat is accepted when i_valid=1; each acceptance is a shift event and decrements the beat counter.
REQ-018 RUN with i_valid=0: no shift, skew contents hold, o_en_tf=0 next cycle (stall bubble).
REQ-019 Acceptance of the last beat moves to DRAIN with the drain counter loaded to LANES-1.
REQ-020 DRAIN: o_ready=0; a shift event every cycle, injecting zero into every lane; the counter decrements; at 1 -> DONE (for LANES=1, DRAIN is skipped and RUN goes straight to DONE).
REQ-021 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-022 Skew: lane k has k+1 register stages; lane k of the beat accepted at shift event t appears on o_fmap from the cycle after shift event t+k.
REQ-023 o_fmap holds its value between shift events; lanes not yet filled read zero.
REQ-024 i_start is ignored outside IDLE; i_len is not re-sampled mid-pass.
REQ-025 i_fmap is ignored when o_ready=0 or i_valid=0.

Reset
REQ-026 rst asserted asynchronously forces IDLE, clears all skew registers and counters; o_fmap=0, o_ready=0, o_en_tf=0, o_busy=0, o_done=0.
REQ-027 rst mid-pass discards all in-flight data; no o_done pulse is produced.

Configuration
REQ-028 Macro FEEDER_STALL_CNT_EN: when defined, adds output o_stall_cnt (LEN_BW bits), cleared on entry to RUN, incremented on every RUN cycle with i_valid=0, saturating at all-ones, held after the pass; when undefined, the port and counter do not exist and behaviour is otherwise identical.

Structure
REQ-029 Shared package tile_pkg holds D_BW, the feeder state typedef and its encodings.
REQ-030 Sub-module skew_lane: a parameter-depth D_BW shift register with shift-enable and async clear, one instance per lane.

Verification
REQ-031 LANES=4, i_len=3, i_valid held high, beats A,B,C (lane k = beat+k) -> lane 0 shows A,B,C on cycles 1-3 after the first acceptance; lane 3 shows A on cycle 4 and C on cycle 6; o_done pulses once after 3 DRAIN cycles.
REQ-032 LANES=4, i_len=2, i_valid low for 2 cycles between beats -> o_en_tf low for those 2 cycles, o_fmap frozen, and the final skew identical to the no-stall run.
REQ-033 i_start with i_len=0 -> DONE next cycle, o_done pulse, o_en_tf never asserted.
REQ-034 rst pulsed during DRAIN -> all outputs 0 asynchronously, no o_done; a new pass afterwards starts from a clean zeroed array.
REQ-035 i_start asserted again during RUN -> ignored; beat count unchanged.
REQ-036 FEEDER_STALL_CNT_EN defined, 5 stall cycles in RUN -> o_stall_cnt=5 after DONE; undefined build compiles without the port.
